// File: rtl/main_memory.sv
// rtl/main_memory.sv - line-granular backing memory with I/D fill arbiter and writeback FIFO
module main_memory #(
    parameter int WORD_SIZE = 32,
    parameter int LINE_SIZE = 128,
    parameter int MEM_LINES = 256,
    parameter int MEM_DELAY = 5,
    parameter int WB_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_req,
    input  logic [WORD_SIZE-1:0] imem_req_addr,
    output logic                 imem_res,
    output logic [WORD_SIZE-1:0] imem_res_addr,
    output logic [LINE_SIZE-1:0] imem_res_data,
    input  logic                 dmem_req,
    input  logic [WORD_SIZE-1:0] dmem_req_addr,
    input  logic                 dmem_write,
    input  logic [WORD_SIZE-1:0] dmem_write_addr,
    input  logic [LINE_SIZE-1:0] dmem_write_data,
    output logic                 dmem_write_full,
    output logic                 dmem_res,
    output logic [WORD_SIZE-1:0] dmem_res_addr,
    output logic [LINE_SIZE-1:0] dmem_res_data
);
    localparam int OFF  = $clog2(LINE_SIZE / 8);
    localparam int IW   = $clog2(MEM_LINES);
    localparam int CNTW = $clog2(MEM_DELAY) + 1;
    localparam int PW   = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CW   = $clog2(WB_DEPTH + 1);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~(WORD_SIZE'((1 << OFF) - 1));

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESPOND} state_t;

    state_t                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d, op_dport_q, op_dport_d;
    logic [WORD_SIZE-1:0]  op_addr_q, op_addr_d;
    logic [LINE_SIZE-1:0]  op_data_q, op_data_d;
    logic                  i_pend_q, i_pend_d, i_svc_q, i_svc_d;
    logic                  d_pend_q, d_pend_d, d_svc_q, d_svc_d;
    logic [WORD_SIZE-1:0]  i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  imem_res_q, imem_res_d, dmem_res_q, dmem_res_d;
    logic [WORD_SIZE-1:0]  imem_res_addr_q, imem_res_addr_d, dmem_res_addr_q, dmem_res_addr_d;
    logic [LINE_SIZE-1:0]  imem_res_data_q, imem_res_data_d, dmem_res_data_q, dmem_res_data_d;

    logic [WORD_SIZE-1:0]  wb_addr [WB_DEPTH];
    logic [LINE_SIZE-1:0]  wb_data [WB_DEPTH];
    // Zero at power-up only; reset deliberately leaves the image intact.
    logic [LINE_SIZE-1:0]  storage [MEM_LINES] = '{default: '0};

    logic wb_full, wb_empty, free, done, i_cap, d_cap;
    logic sel_wr, sel_d, sel_i, pop, push, mem_we;
    logic [IW-1:0] op_idx;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wb_full  = (count_q == CW'(WB_DEPTH));
        wb_empty = (count_q == '0);
        free     = (state_q == S_IDLE) || (state_q == S_RESPOND);
        done     = (state_q == S_BUSY) && (cnt_q == '0);
        op_idx   = op_addr_q[OFF +: IW];
        mem_we   = done && op_wr_q;
        i_cap    = imem_req && !i_pend_q && !i_svc_q;
        d_cap    = dmem_req && !d_pend_q && !d_svc_q;
        // An incoming writeback with an empty FIFO is served directly without being stored.
        sel_wr   = free && (!wb_empty || dmem_write);
        pop      = sel_wr && !wb_empty;
        push     = dmem_write && !(sel_wr && wb_empty) && (!wb_full || pop);
        sel_d    = free && !sel_wr && (d_pend_q || d_cap);
        sel_i    = free && !sel_wr && !sel_d && (i_pend_q || i_cap);

        head_d   = pop ? ptr_next(head_q) : head_q;
        tail_d   = push ? ptr_next(tail_q) : tail_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        i_addr_d = i_cap ? (imem_req_addr & ALIGN_MASK) : i_addr_q;
        d_addr_d = d_cap ? (dmem_req_addr & ALIGN_MASK) : d_addr_q;
        i_pend_d = (i_pend_q || i_cap) && !sel_i;
        d_pend_d = (d_pend_q || d_cap) && !sel_d;
        i_svc_d  = (i_svc_q && !(state_q == S_RESPOND && !op_dport_q)) || sel_i;
        d_svc_d  = (d_svc_q && !(state_q == S_RESPOND && op_dport_q)) || sel_d;

        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        op_dport_d = op_dport_q;
        op_addr_d  = op_addr_q;
        op_data_d  = op_data_q;
        case (state_q)
            S_IDLE, S_RESPOND: begin
                state_d = S_IDLE;
                if (sel_wr || sel_d || sel_i) begin
                    state_d    = S_BUSY;
                    cnt_d      = CNTW'(MEM_DELAY - 1);
                    op_wr_d    = sel_wr;
                    op_dport_d = !sel_i;
                    if (sel_wr) begin
                        op_addr_d = pop ? wb_addr[head_q] : (dmem_write_addr & ALIGN_MASK);
                        op_data_d = pop ? wb_data[head_q] : dmem_write_data;
                    end else if (sel_d) begin
                        op_addr_d = d_pend_q ? d_addr_q : (dmem_req_addr & ALIGN_MASK);
                    end else begin
                        op_addr_d = i_pend_q ? i_addr_q : (imem_req_addr & ALIGN_MASK);
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) state_d = op_wr_q ? S_IDLE : S_RESPOND;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        imem_res_d      = done && !op_wr_q && !op_dport_q;
        dmem_res_d      = done && !op_wr_q && op_dport_q;
        imem_res_addr_d = imem_res_d ? op_addr_q : imem_res_addr_q;
        imem_res_data_d = imem_res_d ? storage[op_idx] : imem_res_data_q;
        dmem_res_addr_d = dmem_res_d ? op_addr_q : dmem_res_addr_q;
        dmem_res_data_d = dmem_res_d ? storage[op_idx] : dmem_res_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            op_wr_q         <= 1'b0;
            op_dport_q      <= 1'b0;
            op_addr_q       <= '0;
            op_data_q       <= '0;
            i_pend_q        <= 1'b0;
            i_svc_q         <= 1'b0;
            d_pend_q        <= 1'b0;
            d_svc_q         <= 1'b0;
            i_addr_q        <= '0;
            d_addr_q        <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            imem_res_q      <= 1'b0;
            dmem_res_q      <= 1'b0;
            imem_res_addr_q <= '0;
            imem_res_data_q <= '0;
            dmem_res_addr_q <= '0;
            dmem_res_data_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            op_wr_q         <= op_wr_d;
            op_dport_q      <= op_dport_d;
            op_addr_q       <= op_addr_d;
            op_data_q       <= op_data_d;
            i_pend_q        <= i_pend_d;
            i_svc_q         <= i_svc_d;
            d_pend_q        <= d_pend_d;
            d_svc_q         <= d_svc_d;
            i_addr_q        <= i_addr_d;
            d_addr_q        <= d_addr_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            imem_res_q      <= imem_res_d;
            dmem_res_q      <= dmem_res_d;
            imem_res_addr_q <= imem_res_addr_d;
            imem_res_data_q <= imem_res_data_d;
            dmem_res_addr_q <= dmem_res_addr_d;
            dmem_res_data_q <= dmem_res_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail_q] <= dmem_write_addr & ALIGN_MASK;
            wb_data[tail_q] <= dmem_write_data;
        end
        if (mem_we) storage[op_idx] <= op_data_q;
    end

    assign imem_res        = imem_res_q;
    assign imem_res_addr   = imem_res_addr_q;
    assign imem_res_data   = imem_res_data_q;
    assign dmem_res        = dmem_res_q;
    assign dmem_res_addr   = dmem_res_addr_q;
    assign dmem_res_data   = dmem_res_data_q;
    assign dmem_write_full = wb_full;
endmodule
